// File: rtl/cmac_seq.sv
// Sequencer that streams operand pairs into an external complex MAC and
// captures the dot-product result of a job.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; len=0 jobs complete immediately via DONE
// FIRST | waiting for the first pair; its product seeds product and acc
// MUL   | waiting for the next pair; its product loads the product register
// ADD   | acc <= acc + product; no input accepted
// DONE  | one-cycle res_valid pulse, then back to IDLE
module cmac_seq #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                abs_mode,
    input  logic                in_valid,
    input  logic [2*DATA_W-1:0] in_a,
    input  logic [2*DATA_W-1:0] in_b,
    output logic                in_ready,
    output logic [2*DATA_W-1:0] cm_A,
    output logic [2*DATA_W-1:0] cm_B,
    output logic                cm_acc,
    output logic                cm_abs,
    output logic                cm_acc_en,
    output logic                cm_mult_en,
    input  logic [2*DATA_W-1:0] cm_S,
    input  logic                cm_overflow,
    output logic [2*DATA_W-1:0] res,
    output logic                res_valid,
    output logic                res_ovf,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        MUL,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             abs_q;
    logic [LEN_W:0]   cnt;
    logic             ovf_q;
    logic             hs;
    logic             ovf_now;

    assign cm_A     = in_a;
    assign cm_B     = in_b;
    assign in_ready = (state == FIRST) || (state == MUL);
    assign hs       = in_ready && in_valid;

    // MAC controls follow the handshake in the same cycle, so they are decoded
    // from the state register and in_valid rather than registered.
    always_comb begin
        cm_acc     = 1'b0;
        cm_abs     = 1'b0;
        cm_acc_en  = 1'b0;
        cm_mult_en = 1'b0;
        case (state)
            FIRST: begin
                cm_mult_en = hs;
                cm_acc_en  = hs;
                cm_abs     = hs && abs_q;
            end
            MUL: begin
                cm_mult_en = hs;
                cm_abs     = hs && abs_q;
            end
            ADD: begin
                cm_acc    = 1'b1;
                cm_acc_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Overflow including the current MAC operation, so the final write cycle
    // is folded into res_ovf.
    assign ovf_now = ovf_q | (cm_overflow & (cm_mult_en | cm_acc_en));

    // Sequencer state, job registers and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            abs_q     <= 1'b0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            res       <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            len_q <= len;
                            abs_q <= abs_mode;
                            ovf_q <= 1'b0;
                            cnt   <= '0;
                            state <= FIRST;
                        end else begin
                            res       <= '0;
                            res_ovf   <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                FIRST: begin
                    ovf_q <= ovf_now;
                    if (hs) begin
                        cnt <= cnt + (LEN_W+1)'(1);
                        if (len_q == LEN_W'(1)) begin
                            res       <= cm_S;
                            res_ovf   <= ovf_now;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    ovf_q <= ovf_now;
                    if (hs) begin
                        cnt   <= cnt + (LEN_W+1)'(1);
                        state <= ADD;
                    end
                end
                ADD: begin
                    ovf_q <= ovf_now;
                    if (cnt == {1'b0, len_q}) begin
                        res       <= cm_S;
                        res_ovf   <= ovf_now;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmac_seq.sv
// Bench for cmac_seq: a behavioural complex MAC drives cm_S, and a job-level
// model (terms taken, add pending, running sum) predicts every output cycle.
module tb_cmac_seq;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [LEN_W-1:0]    len = '0;
    logic                abs_mode = 1'b0;
    logic                in_valid = 1'b0;
    logic [2*DATA_W-1:0] in_a = '0;
    logic [2*DATA_W-1:0] in_b = '0;
    logic                in_ready;
    logic [2*DATA_W-1:0] cm_A, cm_B, cm_S;
    logic                cm_acc, cm_abs, cm_acc_en, cm_mult_en;
    logic                cm_overflow = 1'b0;
    logic [2*DATA_W-1:0] res;
    logic                res_valid, res_ovf, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    cmac_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abs_mode(abs_mode),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .cm_A(cm_A), .cm_B(cm_B), .cm_acc(cm_acc), .cm_abs(cm_abs),
        .cm_acc_en(cm_acc_en), .cm_mult_en(cm_mult_en), .cm_S(cm_S),
        .cm_overflow(cm_overflow), .res(res), .res_valid(res_valid),
        .res_ovf(res_ovf), .busy(busy)
    );

    // Complex product; abs mode multiplies by the conjugate of B.
    function automatic logic [63:0] cmul(input logic [63:0] a, input logic [63:0] b, input logic ab);
        logic [31:0] ar, ai, br, bi, rr, ri;
        ar = a[63:32]; ai = a[31:0]; br = b[63:32]; bi = b[31:0];
        if (ab) begin
            rr = ar * br + ai * bi;
            ri = ai * br - ar * bi;
        end else begin
            rr = ar * br - ai * bi;
            ri = ar * bi + ai * br;
        end
        return {rr, ri};
    endfunction

    function automatic logic [63:0] cadd(input logic [63:0] a, input logic [63:0] b);
        return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
    endfunction

    // Behavioural complex MAC: product and accumulator registers.
    logic [63:0] mac_p, mac_acc, mac_mult;
    assign mac_mult = cmul(cm_A, cm_B, cm_abs);
    assign cm_S     = cm_acc ? cadd(mac_acc, mac_p) : mac_mult;
    always @(posedge clk) begin
        if (rst) begin
            mac_p   <= '0;
            mac_acc <= '0;
        end else begin
            if (cm_mult_en) mac_p   <= mac_mult;
            if (cm_acc_en)  mac_acc <= cm_S;
        end
    end

    // Job-level reference model.
    logic        m_busy = 0, m_done = 0, m_add = 0, m_abs = 0, m_ovf = 0, m_res_ovf = 0;
    logic [8:0]  m_taken = 0;
    logic [7:0]  m_n = 0;
    logic [63:0] m_sum = 0, m_res = 0, m_sum_next;
    logic        e_ready, e_hs, e_mult, e_acc_en, e_acc, e_abs, m_ovf_now;

    always_comb begin
        e_ready  = m_busy && !m_done && !m_add;
        e_hs     = e_ready && in_valid;
        e_mult   = e_hs;
        e_acc_en = (e_hs && m_taken == 0) || m_add;
        e_acc    = m_add;
        e_abs    = e_hs && m_abs;
    end
    assign m_ovf_now  = m_ovf | (cm_overflow & (e_mult | e_acc_en));
    assign m_sum_next = cadd(m_sum, cmul(in_a, in_b, m_abs));

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_add <= 0; m_taken <= 0;
            m_ovf <= 0; m_res <= 0; m_res_ovf <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1;
                if (len == 0) begin
                    m_done <= 1; m_res <= 0; m_res_ovf <= 0;
                end else begin
                    m_n <= len; m_abs <= abs_mode; m_taken <= 0;
                    m_sum <= 0; m_ovf <= 0; m_add <= 0;
                end
            end
        end else if (m_done) begin
            m_busy <= 0; m_done <= 0;
        end else begin
            m_ovf <= m_ovf_now;
            if (e_hs) begin
                m_sum   <= m_sum_next;
                m_taken <= m_taken + 9'd1;
                if (m_taken == 0) begin
                    if (m_n == 1) begin
                        m_done <= 1; m_res <= m_sum_next; m_res_ovf <= m_ovf_now;
                    end
                end else begin
                    m_add <= 1;
                end
            end else if (m_add) begin
                m_add <= 0;
                if (m_taken == {1'b0, m_n}) begin
                    m_done <= 1; m_res <= m_sum; m_res_ovf <= m_ovf_now;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl", {121'd0, in_ready, cm_acc, cm_abs, cm_acc_en, cm_mult_en, busy, res_valid},
                        {121'd0, e_ready, e_acc, e_abs, e_acc_en, e_mult, m_busy, m_done});
            chk("res", {64'd0, res}, {64'd0, m_res});
            chk("res_ovf", {127'd0, res_ovf}, {127'd0, m_res_ovf});
            chk("cm_ops", {cm_A, cm_B}, {in_a, in_b});
        end
    end

    logic [63:0] qa[$], qb[$];

    // ovfm: 0 random overflow, 1 none, 2 only during the first ADD (all-valid jobs)
    task automatic run_job(input int n, input bit ab, input int vprob, input int stall,
                           input int ovfm, output logic [63:0] r, output logic ro, output int cyc);
        bit hs, got;
        int taken, lowc;
        got = 0; taken = 0; lowc = 0; cyc = -1; r = 'x; ro = 1'bx;
        @(posedge clk); #1;
        start = 1; len = LEN_W'(n); abs_mode = ab;
        for (int b = 0; b < 2000; b++) begin
            @(negedge clk);
            if (b > 0 && res_valid) begin
                r = res; ro = res_ovf; cyc = b; got = 1;
                break;
            end
            hs = in_ready && in_valid;
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            len = LEN_W'($urandom_range(0, 255));
            abs_mode = $urandom_range(0, 1);
            if (hs) begin
                taken++;
                if (qa.size() > 0) begin void'(qa.pop_front()); void'(qb.pop_front()); end
                if (taken == 1) lowc = stall;
            end
            in_a = (qa.size() > 0) ? qa[0] : {$urandom, $urandom};
            in_b = (qb.size() > 0) ? qb[0] : {$urandom, $urandom};
            if (lowc > 0) begin
                in_valid = 0; lowc--;
            end else begin
                in_valid = (vprob >= 100) ? 1'b1 : ($urandom_range(1, 100) <= vprob);
            end
            case (ovfm)
                0: cm_overflow = ($urandom_range(0, 15) == 0);
                1: cm_overflow = 1'b0;
                default: cm_overflow = (b == 2);
            endcase
        end
        start = 0; in_valid = 0; cm_overflow = 0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL job_timeout: got no res_valid expected res_valid len=%0d", n);
        end
    endtask

    logic [63:0] r;
    logic        ro;
    int          cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset_state", {124'd0, busy, res_valid, res_ovf, in_ready}, 128'd0);
        chk("reset_res", {64'd0, res}, 128'd0);

        // single term (2,0)x(3,0)
        qa = '{{32'd2, 32'd0}}; qb = '{{32'd3, 32'd0}};
        run_job(1, 0, 100, 0, 1, r, ro, cyc);
        chk("len1_res", {64'd0, r}, {64'd0, 32'd6, 32'd0});
        chk("len1_cycles", 128'(cyc), 128'd2);

        // three terms -> (2,3) in 5 active cycles
        qa = '{{32'd1, 32'd1}, {32'd2, 32'd0}, {32'd1, 32'd0}};
        qb = '{{32'd1, 32'd0}, {32'd0, 32'd1}, {32'd1, 32'd0}};
        run_job(3, 0, 100, 0, 1, r, ro, cyc);
        chk("len3_res", {64'd0, r}, {64'd0, 32'd2, 32'd3});
        chk("len3_cycles", 128'(cyc), 128'd6);

        // two terms, unstalled then stalled for 3 cycles in MUL -> (4,8)
        qa = '{{32'd1, 32'd2}, {32'd3, 32'd1}}; qb = '{{32'd2, 32'd0}, {32'd1, 32'd1}};
        run_job(2, 0, 100, 0, 1, r, ro, cyc);
        chk("len2_res", {64'd0, r}, {64'd0, 32'd4, 32'd8});
        qa = '{{32'd1, 32'd2}, {32'd3, 32'd1}}; qb = '{{32'd2, 32'd0}, {32'd1, 32'd1}};
        run_job(2, 0, 100, 3, 1, r, ro, cyc);
        chk("stall_res", {64'd0, r}, {64'd0, 32'd4, 32'd8});
        chk("stall_cycles", 128'(cyc), 128'd7);

        // abs mode (1,2)*conj(3,1) = (5,5)
        qa = '{{32'd1, 32'd2}}; qb = '{{32'd3, 32'd1}};
        run_job(1, 1, 100, 0, 1, r, ro, cyc);
        chk("abs_res", {64'd0, r}, {64'd0, 32'd5, 32'd5});

        // empty job
        run_job(0, 0, 100, 0, 1, r, ro, cyc);
        chk("len0_res", {63'd0, r, ro}, 128'd0);
        chk("len0_cycles", 128'(cyc), 128'd1);

        // overflow in the first ADD is sticky to DONE, then cleared by the next job
        run_job(3, 0, 100, 0, 2, r, ro, cyc);
        chk("ovf_set", {127'd0, ro}, 128'd1);
        run_job(2, 0, 100, 0, 1, r, ro, cyc);
        chk("ovf_clear", {127'd0, ro}, 128'd0);

        // reset during the second MUL of a len=4 job
        @(posedge clk); #1;
        start = 1; len = 8'd4; in_valid = 1; cm_overflow = 0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0; in_valid = 0;
        @(negedge clk);
        chk("rst_mid_busy", {126'd0, busy, res_valid}, 128'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_valid", {127'd0, res_valid}, 128'd0);
        end
        qa = '{{32'd1, 32'd2}, {32'd3, 32'd1}}; qb = '{{32'd2, 32'd0}, {32'd1, 32'd1}};
        run_job(2, 0, 100, 0, 1, r, ro, cyc);
        chk("after_rst_res", {64'd0, r}, {64'd0, 32'd4, 32'd8});

        // randomized jobs, checked each cycle by the model
        for (int j = 0; j < 40; j++) begin
            run_job(($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 6),
                    $urandom_range(0, 1), $urandom_range(30, 100),
                    $urandom_range(0, 2), 0, r, ro, cyc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmac_seq.md
CMAC_SEQ -- requirements
Module: cmac_seq

Interface
REQ-001 Parameter DATA_W, default 32, width of one real/imaginary component.
REQ-002 Parameter LEN_W, default 8, width of the term-count input.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a dot-product job; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of operand pairs in the job; latched on accepted start.
REQ-007 abs_mode  input  1  latched on accepted start; selects the CMAC abs operation for multiplies.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_a  input  2*DATA_W  operand A, {real, imag}.
REQ-010 in_b  input  2*DATA_W  operand B, {real, imag}.
REQ-011 in_ready  output  1  operand pair accepted when in_valid and in_ready are both high.
REQ-012 cm_A, cm_B  output  2*DATA_W each  operands to the complex MAC; combinational copies of in_a and in_b.
REQ-013 cm_acc, cm_abs, cm_acc_en, cm_mult_en  output  1 each  complex MAC controls.
REQ-014 cm_S  input  2*DATA_W  complex MAC combinational result.
REQ-015 cm_overflow  input  1  complex MAC overflow flag for the current operation.
REQ-016 res  output  2*DATA_W  captured job result.
REQ-017 res_valid  output  1  one-cycle pulse; res is valid.
REQ-018 res_ovf  output  1  sticky overflow for the job, valid with res_valid.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, FIRST, MUL, ADD and DONE.
REQ-021 In IDLE, start=1 with len>=1 SHALL latch len and abs_mode, clear the overflow flag and the term counter, and go to FIRST.
REQ-022 In IDLE, start=1 with len=0 SHALL set res=0 and res_ovf=0, and go to DONE.
REQ-023 in_ready SHALL be 1 only in FIRST and MUL.
REQ-024 On a handshake in FIRST, the block SHALL drive cm_acc=0, cm_mult_en=1, cm_acc_en=1 and cm_abs=abs_mode, so that the product seeds both MAC registers.
REQ-025 On a handshake in MUL, the block SHALL drive cm_acc=0, cm_mult_en=1, cm_acc_en=0 and cm_abs=abs_mode.
REQ-026 In ADD, the block SHALL drive cm_acc=1, cm_acc_en=1, cm_mult_en=0 and cm_abs=0, and no input SHALL be accepted.
REQ-027 In FIRST or MUL without a handshake, all cm_ control outputs SHALL be 0 and the state SHALL hold (stall).
REQ-028 In IDLE and DONE, all cm_ control outputs SHALL be 0.
REQ-029 Each handshake SHALL increment the term counter (LEN_W+1 bits).
REQ-030 FIRST SHALL go to DONE if len=1; otherwise it SHALL go to MUL. MUL SHALL go to ADD.
REQ-031 ADD SHALL go to DONE when the counter equals len; otherwise it SHALL go to MUL.
REQ-032 res SHALL capture cm_S on the final write cycle: the FIRST handshake when len=1, or the last ADD cycle otherwise.
REQ-033 The overflow flag SHALL OR in cm_overflow on every cycle with cm_mult_en or cm_acc_en high.
REQ-034 res_ovf SHALL be the flag value including the final write cycle.
REQ-035 DONE SHALL last one cycle with res_valid=1 and SHALL then return to IDLE.
REQ-036 res and res_ovf SHALL hold their values until the next capture.
REQ-037 A start while busy SHALL be ignored. in_valid outside FIRST and MUL SHALL be ignored.
REQ-038 With in_valid held high, a job of N>=1 terms SHALL occupy 2N-1 cycles from FIRST, followed by 1 DONE cycle.

Reset
REQ-039 With rst=1, the next state SHALL be IDLE, and res=0, res_valid=0, res_ovf=0, busy=0, all cm_ controls 0, and the counter 0.
REQ-040 A reset mid-job SHALL abandon the job with no res_valid; the complex MAC is reset by the same rst.

Verification
REQ-041 len=1, a=(2,0), b=(3,0), in_valid high -> FIRST cycle drives mult_en=1, acc_en=1, acc=0; DONE next cycle with res=cm_S=(6,0) and res_valid for 1 cycle.
REQ-042 len=3, pairs (1,1)x(1,0), (2,0)x(0,1), (1,0)x(1,0), with a real complex MAC instance -> 5 active cycles (FIRST,MUL,ADD,MUL,ADD), res=(2,3).
REQ-043 len=2 with in_valid low for 3 cycles in MUL -> controls 0 during the stall; the result is identical to the unstalled run.
REQ-044 len=0 -> res_valid one cycle after start, res=0, res_ovf=0, no cm_ enables asserted.
REQ-045 cm_overflow forced high during the first ADD of a len=3 job -> res_ovf=1 at DONE; the next job with no overflow -> res_ovf=0.
REQ-046 rst asserted in the second MUL of a len=4 job -> IDLE next cycle, busy=0, no res_valid; a new start runs normally.
